// File: rtl/apu_pkg.sv
// Shared types and helpers for the APU serial front end.
package apu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } bit_state_e;

  typedef enum logic {
    F_IDLE,
    F_DATA
  } frm_state_e;

  localparam logic [4:0] APU_REG_MAX = 5'h17;

  function automatic int unsigned baud_div(input int unsigned clkrate,
                                           input int unsigned baudrate);
    return clkrate / baudrate;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-FF synchronizer, bit FSM, byte and error strobes.
// UART_PARITY_EN selects 8E1 framing; otherwise 8N1.
module uart_rx_core
  import apu_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_error
);

  localparam int unsigned HALF = BAUD_DIV / 2;
  localparam int unsigned CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(BAUD_DIV - 1);

  logic          rx_meta;
  logic          rx_sync;
  bit_state_e    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          valid_pend;
  logic          error_pend;
`ifdef UART_PARITY_EN
  logic          par_bad;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_error   <= 1'b0;
      valid_pend <= 1'b0;
      error_pend <= 1'b0;
`ifdef UART_PARITY_EN
      par_bad    <= 1'b0;
`endif
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_valid   <= valid_pend;
      rx_error   <= error_pend;
      valid_pend <= 1'b0;
      error_pend <= 1'b0;
      cnt        <= cnt + 1'b1;
      case (state)
        IDLE: begin
          // cnt tracks cycles since rx_sync first went low
          if (!rx_sync) begin
            state <= START;
            cnt   <= CW'(1);
          end else begin
            cnt <= '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? IDLE : DATA;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shift   <= {rx_sync, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            par_bad <= rx_sync ^ (^shift);
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (!rx_sync) begin
              error_pend <= 1'b1;
              state      <= BREAK;
`ifdef UART_PARITY_EN
            end else if (par_bad) begin
              error_pend <= 1'b1;
              state      <= IDLE;
`endif
            end else begin
              rx_data    <= shift;
              valid_pend <= 1'b1;
              state      <= IDLE;
            end
          end
        end
        BREAK: begin
          // line held low after a framing error: wait for idle level before rearming
          cnt <= '0;
          if (rx_sync) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/serial_reg_rx.sv
// Serial front end of the APU: UART bytes paired into (address, data) register writes.
// UART_PARITY_EN selects 8E1 framing in the receiver core.
module serial_reg_rx
  import apu_pkg::*;
#(
  parameter int unsigned CLKRATE  = 2_000_000,
  parameter int unsigned BAUDRATE = 9600,
  parameter int unsigned TIMEOUT  = 20,
  parameter int unsigned LINKHOLD = 200_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_error,
  output logic [4:0] reg_addr,
  output logic [7:0] reg_data,
  output logic       reg_we,
  output logic       link
);

  localparam int unsigned BAUD_DIV = baud_div(CLKRATE, BAUDRATE);
  localparam int unsigned TMO_CYCLES = TIMEOUT * BAUD_DIV;
  localparam int unsigned TW = $clog2(TMO_CYCLES + 1);
  localparam int unsigned LW = $clog2(LINKHOLD + 1);

  frm_state_e    f_state;
  logic [4:0]    addr_q;
  logic [TW-1:0] tmo_cnt;
  logic [LW-1:0] link_cnt;

  uart_rx_core #(
    .BAUD_DIV (BAUD_DIV)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_error (rx_error)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_state  <= F_IDLE;
      addr_q   <= '0;
      tmo_cnt  <= '0;
      reg_addr <= '0;
      reg_data <= '0;
      reg_we   <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      if (rx_error) begin
        f_state <= F_IDLE;
      end else begin
        case (f_state)
          F_IDLE: begin
            tmo_cnt <= '0;
            if (rx_valid && (rx_data <= {3'b000, APU_REG_MAX})) begin
              addr_q  <= rx_data[4:0];
              f_state <= F_DATA;
            end
          end
          F_DATA: begin
            if (rx_valid) begin
              reg_addr <= addr_q;
              reg_data <= rx_data;
              reg_we   <= 1'b1;
              f_state  <= F_IDLE;
            end else if (tmo_cnt == TW'(TMO_CYCLES - 1)) begin
              // orphaned address byte: drop it so the next byte is treated as an address
              f_state <= F_IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          default: f_state <= F_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_cnt <= '0;
    end else if (rx_valid) begin
      link_cnt <= LW'(LINKHOLD);
    end else if (link_cnt != '0) begin
      link_cnt <= link_cnt - 1'b1;
    end
  end

  assign link = (link_cnt != '0);

endmodule

// File: tb/tb_serial_reg_rx.sv
// Randomised self-checking bench for serial_reg_rx with a scaled-down baud rate.
module tb_serial_reg_rx;

  localparam int unsigned CLKRATE  = 160;
  localparam int unsigned BAUDRATE = 10;
  localparam int unsigned TIMEOUT  = 20;
  localparam int unsigned LINKHOLD = 300;
  localparam int unsigned BD   = CLKRATE / BAUDRATE;
  localparam int unsigned HALF = BD / 2;
`ifdef UART_PARITY_EN
  localparam int unsigned LAT = HALF + 10 * BD + 1;
`else
  localparam int unsigned LAT = HALF + 9 * BD + 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;
  logic [4:0] reg_addr;
  logic [7:0] reg_data;
  logic       reg_we;
  logic       link;

  int errs = 0;
  int checks = 0;

  serial_reg_rx #(
    .CLKRATE  (CLKRATE),
    .BAUDRATE (BAUDRATE),
    .TIMEOUT  (TIMEOUT),
    .LINKHOLD (LINKHOLD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_error (rx_error),
    .reg_addr (reg_addr),
    .reg_data (reg_data),
    .reg_we   (reg_we),
    .link     (link)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder: every strobe seen on the outputs, with its cycle stamp.
  logic [7:0]  vq[$];
  int unsigned vcyc[$];
  logic [12:0] wq[$];
  int unsigned wcyc[$];
  int unsigned err_seen = 0;
  int unsigned link_hi = 0;

  always @(negedge clk) begin
    if (rx_valid) begin
      vq.push_back(rx_data);
      vcyc.push_back(cyc);
    end
    if (reg_we) begin
      wq.push_back({reg_addr, reg_data});
      wcyc.push_back(cyc);
    end
    if (rx_error) err_seen++;
    if (link) link_hi++;
  end

  int unsigned start_cyc;

  task automatic idle(input int unsigned n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit par_ok);
    @(negedge clk);
    rx = 1'b0;
    start_cyc = cyc;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BD) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    rx = par_ok ? ^b : ~(^b);
    repeat (BD) @(negedge clk);
`else
    if (!par_ok) rx = 1'b1;
`endif
    rx = stop_ok;
    repeat (BD) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic settle();
    idle(4);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (rx_data !== 8'h00) begin errs++; $display("FAIL reset_rx_data got %0h want 0", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errs++; $display("FAIL reset_rx_valid got %0b want 0", rx_valid); end
    checks++; if (rx_error !== 1'b0) begin errs++; $display("FAIL reset_rx_error got %0b want 0", rx_error); end
    checks++; if (reg_addr !== 5'h00) begin errs++; $display("FAIL reset_reg_addr got %0h want 0", reg_addr); end
    checks++; if (reg_data !== 8'h00) begin errs++; $display("FAIL reset_reg_data got %0h want 0", reg_data); end
    checks++; if (reg_we !== 1'b0) begin errs++; $display("FAIL reset_reg_we got %0b want 0", reg_we); end
    checks++; if (link !== 1'b0) begin errs++; $display("FAIL reset_link got %0b want 0", link); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2 * BD);
  endtask

  task automatic test_single_byte();
    int vb = vq.size();
    int unsigned lb = link_hi;
    int unsigned n = 0;
    send_byte(8'h55, 1'b1, 1'b1);
    settle();
    checks++; if (vq.size() - vb !== 1) begin errs++; $display("FAIL single_count got %0d want 1", vq.size() - vb); end
    if (vq.size() > vb) begin
      checks++; if (vq[vb] !== 8'h55) begin errs++; $display("FAIL single_data got %0h want 55", vq[vb]); end
      checks++;
      if (vcyc[vb] - start_cyc !== LAT + 2) begin
        errs++; $display("FAIL single_latency got %0d want %0d", vcyc[vb] - start_cyc, LAT + 2);
      end
    end
    checks++; if (rx_data !== 8'h55) begin errs++; $display("FAIL single_hold got %0h want 55", rx_data); end
    while (link && n < LINKHOLD + 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #1;
    checks++; if (link !== 1'b0) begin errs++; $display("FAIL link_drop got %0b want 0", link); end
    checks++;
    if (link_hi - lb !== LINKHOLD) begin
      errs++; $display("FAIL link_length got %0d want %0d", link_hi - lb, LINKHOLD);
    end
  endtask

  task automatic test_pair();
    int wb = wq.size();
    int vb = vq.size();
    send_byte(8'h15, 1'b1, 1'b1);
    #1;
    checks++; if (wq.size() !== wb) begin errs++; $display("FAIL pair_early_we got %0d want %0d", wq.size(), wb); end
    send_byte(8'h0F, 1'b1, 1'b1);
    settle();
    checks++; if (wq.size() - wb !== 1) begin errs++; $display("FAIL pair_count got %0d want 1", wq.size() - wb); end
    if (wq.size() > wb && vq.size() > vb + 1) begin
      checks++; if (wq[wb] !== {5'h15, 8'h0F}) begin errs++; $display("FAIL pair_value got %0h want %0h", wq[wb], {5'h15, 8'h0F}); end
      checks++; if (wcyc[wb] !== vcyc[vb + 1] + 1) begin errs++; $display("FAIL pair_timing got %0d want %0d", wcyc[wb], vcyc[vb + 1] + 1); end
    end
    idle(3 * BD);
    #1;
    checks++; if (reg_addr !== 5'h15) begin errs++; $display("FAIL pair_addr_hold got %0h want 15", reg_addr); end
    checks++; if (reg_data !== 8'h0F) begin errs++; $display("FAIL pair_data_hold got %0h want 0f", reg_data); end
    checks++; if (wq.size() - wb !== 1) begin errs++; $display("FAIL pair_no_extra got %0d want 1", wq.size() - wb); end
  endtask

  task automatic test_glitch();
    int vb = vq.size();
    int unsigned eb = err_seen;
    @(negedge clk);
    rx = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    idle(2 * BD);
    #1;
    checks++; if (vq.size() !== vb) begin errs++; $display("FAIL glitch_valid got %0d want %0d", vq.size(), vb); end
    checks++; if (err_seen !== eb) begin errs++; $display("FAIL glitch_error got %0d want %0d", err_seen, eb); end
    send_byte(8'hA5, 1'b1, 1'b1);
    settle();
    checks++; if (vq.size() - vb !== 1) begin errs++; $display("FAIL glitch_recover_count got %0d want 1", vq.size() - vb); end
    if (vq.size() > vb) begin
      checks++; if (vq[vb] !== 8'hA5) begin errs++; $display("FAIL glitch_recover_data got %0h want a5", vq[vb]); end
    end
  endtask

  task automatic test_break();
    int vb, wb;
    int unsigned eb;
    send_byte(8'h05, 1'b1, 1'b1);
    vb = vq.size();
    wb = wq.size();
    eb = err_seen;
    send_byte(8'h3C, 1'b0, 1'b1);
    rx = 1'b0;
    repeat (20 * BD) @(negedge clk);
    #1;
    checks++; if (err_seen - eb !== 1) begin errs++; $display("FAIL break_error_count got %0d want 1", err_seen - eb); end
    checks++; if (vq.size() !== vb) begin errs++; $display("FAIL break_no_valid got %0d want %0d", vq.size(), vb); end
    checks++; if (rx_data !== 8'h05) begin errs++; $display("FAIL break_data_kept got %0h want 05", rx_data); end
    idle(2 * BD);
    send_byte(8'h03, 1'b1, 1'b1);
    send_byte(8'h22, 1'b1, 1'b1);
    settle();
    checks++; if (wq.size() - wb !== 1) begin errs++; $display("FAIL break_we_count got %0d want 1", wq.size() - wb); end
    if (wq.size() > wb) begin
      checks++; if (wq[wb] !== {5'h03, 8'h22}) begin errs++; $display("FAIL break_we_value got %0h want %0h", wq[wb], {5'h03, 8'h22}); end
    end
  endtask

  task automatic test_timeout();
    int wb = wq.size();
    send_byte(8'h03, 1'b1, 1'b1);
    idle(40 * BD);
    send_byte(8'h01, 1'b1, 1'b1);
    send_byte(8'h7F, 1'b1, 1'b1);
    settle();
    checks++; if (wq.size() - wb !== 1) begin errs++; $display("FAIL timeout_count got %0d want 1", wq.size() - wb); end
    if (wq.size() > wb) begin
      checks++; if (wq[wb] !== {5'h01, 8'h7F}) begin errs++; $display("FAIL timeout_value got %0h want %0h", wq[wb], {5'h01, 8'h7F}); end
    end
    wb = wq.size();
    send_byte(8'h99, 1'b1, 1'b1);
    send_byte(8'h02, 1'b1, 1'b1);
    send_byte(8'h10, 1'b1, 1'b1);
    settle();
    checks++; if (wq.size() - wb !== 1) begin errs++; $display("FAIL discard_count got %0d want 1", wq.size() - wb); end
    if (wq.size() > wb) begin
      checks++; if (wq[wb] !== {5'h02, 8'h10}) begin errs++; $display("FAIL discard_value got %0h want %0h", wq[wb], {5'h02, 8'h10}); end
    end
  endtask

  task automatic test_reset_mid();
    int vb, wb;
    @(negedge clk);
    rx = 1'b0;
    repeat (BD) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BD) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rx_data !== 8'h00) begin errs++; $display("FAIL midrst_rx_data got %0h want 0", rx_data); end
    checks++; if (reg_addr !== 5'h00) begin errs++; $display("FAIL midrst_reg_addr got %0h want 0", reg_addr); end
    checks++; if (reg_data !== 8'h00) begin errs++; $display("FAIL midrst_reg_data got %0h want 0", reg_data); end
    checks++; if (link !== 1'b0) begin errs++; $display("FAIL midrst_link got %0b want 0", link); end
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    idle(2 * BD);
    #1;
    vb = vq.size();
    wb = wq.size();
    send_byte(8'h0A, 1'b1, 1'b1);
    send_byte(8'h3C, 1'b1, 1'b1);
    settle();
    checks++; if (vq.size() - vb !== 2) begin errs++; $display("FAIL midrst_valid_count got %0d want 2", vq.size() - vb); end
    checks++; if (wq.size() - wb !== 1) begin errs++; $display("FAIL midrst_we_count got %0d want 1", wq.size() - wb); end
    if (wq.size() > wb) begin
      checks++; if (wq[wb] !== {5'h0A, 8'h3C}) begin errs++; $display("FAIL midrst_we_value got %0h want %0h", wq[wb], {5'h0A, 8'h3C}); end
    end
  endtask

  // Reference: every byte is echoed; bytes pair up as (addr<=0x17, data) unless a long
  // silence separates them, in which case the pending address is forgotten.
  task automatic test_random();
    logic [7:0]  exp_v[$];
    logic [12:0] exp_w[$];
    int vb = vq.size();
    int wb = wq.size();
    bit have_addr = 0;
    logic [4:0] addr = '0;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      bit long_gap;
      b = ($urandom % 2 == 0) ? 8'($urandom_range(0, 8'h17)) : 8'($urandom_range(0, 255));
      long_gap = (i == 0) || ($urandom % 3 == 0);
      if (long_gap) idle(30 * BD + $urandom_range(0, BD));
      else idle($urandom_range(0, 2 * BD));
      send_byte(b, 1'b1, 1'b1);
      exp_v.push_back(b);
      if (long_gap) have_addr = 0;
      if (!have_addr) begin
        if (b <= 8'h17) begin
          addr = b[4:0];
          have_addr = 1;
        end
      end else begin
        exp_w.push_back({addr, b});
        have_addr = 0;
      end
    end
    settle();
    checks++; if (vq.size() - vb !== exp_v.size()) begin errs++; $display("FAIL rand_valid_count got %0d want %0d", vq.size() - vb, exp_v.size()); end
    checks++; if (wq.size() - wb !== exp_w.size()) begin errs++; $display("FAIL rand_we_count got %0d want %0d", wq.size() - wb, exp_w.size()); end
    for (int i = 0; i < exp_v.size() && vb + i < vq.size(); i++) begin
      checks++; if (vq[vb + i] !== exp_v[i]) begin errs++; $display("FAIL rand_byte[%0d] got %0h want %0h", i, vq[vb + i], exp_v[i]); end
    end
    for (int i = 0; i < exp_w.size() && wb + i < wq.size(); i++) begin
      checks++; if (wq[wb + i] !== exp_w[i]) begin errs++; $display("FAIL rand_write[%0d] got %0h want %0h", i, wq[wb + i], exp_w[i]); end
    end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    int vb = vq.size();
    int unsigned eb = err_seen;
    idle(2 * BD);
    send_byte(8'h07, 1'b1, 1'b0);
    settle();
    checks++; if (err_seen - eb !== 1) begin errs++; $display("FAIL parity_error got %0d want 1", err_seen - eb); end
    checks++; if (vq.size() !== vb) begin errs++; $display("FAIL parity_no_valid got %0d want %0d", vq.size(), vb); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_pair();
    test_glitch();
    test_break();
    test_timeout();
    test_reset_mid();
    test_random();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errs + 1, checks + 1);
    $fatal(1, "simulation time limit reached");
  end

endmodule
